// File: rtl/histogram_builder.sv
// Grey-level histogram with double-buffered bins: pixels accumulate in one bank
// while the display reads the last published bank, plus max and percentile points.
module histogram_builder #(
  parameter int unsigned BIN_W   = 20,
  parameter int unsigned CLR_LEN = 256
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  input  logic [7:0]       iPixel,
  input  logic             iFrameEnd,
  input  logic [7:0]       iRdAddr,
  output logic [BIN_W-1:0] oRdData,
  output logic [BIN_W-1:0] oMaxValue,
  output logic [7:0]       oThreshPoint25,
  output logic [7:0]       oThreshPoint50,
  output logic [7:0]       oThreshPoint75,
  output logic             oBusy,
  output logic             oFrameDone
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned CUM_W = BIN_W + 2;
  localparam int unsigned CMP_W = BIN_W + 3;
  localparam logic [BIN_W-1:0] BIN_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLR_LEN - 1);

  typedef enum logic [2:0] {CLEAR, ACCUM, DRAIN, SCAN, PUBLISH} stateType;

  stateType          state, nextState;
  logic [IDX_W-1:0]  idx;

  logic [BIN_W-1:0]  accBank [CLR_LEN];
  logic [BIN_W-1:0]  pubBank [CLR_LEN];

  logic              accept;
  logic              p1Valid;
  logic [IDX_W-1:0]  p1Addr;
  logic [BIN_W-1:0]  p1Rd;
  logic              wValid;
  logic [IDX_W-1:0]  wAddr;
  logic [BIN_W-1:0]  wData;
  logic [BIN_W-1:0]  baseVal;
  logic [BIN_W-1:0]  incVal;
  logic [BIN_W-1:0]  pixCount;

  logic [BIN_W-1:0]  scanVal;
  logic [BIN_W-1:0]  maxRun;
  logic [CUM_W-1:0]  cumSum;
  logic [CUM_W-1:0]  cumNext;
  logic [CMP_W-1:0]  cum4;
  logic [CMP_W-1:0]  totK [3];
  logic [IDX_W-1:0]  thrRun [3];
  logic [2:0]        found;

  // State register
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state <= CLEAR;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      CLEAR:   if (idx == LAST_IDX) nextState = ACCUM;
      ACCUM:   if (iFrameEnd) nextState = DRAIN;
      DRAIN:   nextState = SCAN;
      SCAN:    if (idx == LAST_IDX) nextState = PUBLISH;
      PUBLISH: nextState = ACCUM;
      default: nextState = CLEAR;
    endcase
  end

  // Datapath combinational terms
  always_comb begin
    accept  = (state == ACCUM) && iValid;
    // Forward the write retiring this cycle when it hits the same bin
    baseVal = (wValid && (wAddr == p1Addr)) ? wData : p1Rd;
    incVal  = (baseVal == BIN_MAX) ? baseVal : baseVal + BIN_W'(1);
    scanVal = accBank[idx];
    cumNext = cumSum + CUM_W'(scanVal);
    cum4    = CMP_W'({cumNext, 2'b00});
    totK[0] = CMP_W'(pixCount);
    totK[1] = CMP_W'({pixCount, 1'b0});
    totK[2] = totK[0] + totK[1];
  end

  // Bin storage: clear, scan copy-and-zero, or pipelined increment
  always_ff @(posedge iClk) begin
    if (iRst_n) begin
      if (state == CLEAR) begin
        accBank[idx] <= '0;
        pubBank[idx] <= '0;
      end else if (state == SCAN) begin
        pubBank[idx] <= scanVal;
        accBank[idx] <= '0;
      end else if (p1Valid) begin
        accBank[p1Addr] <= incVal;
      end
      if (accept) p1Rd <= accBank[iPixel];
    end
  end

  // Index counter and increment pipeline
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      idx      <= '0;
      p1Valid  <= 1'b0;
      p1Addr   <= '0;
      wValid   <= 1'b0;
      wAddr    <= '0;
      wData    <= '0;
      pixCount <= '0;
      oRdData  <= '0;
    end else begin
      idx      <= ((state == CLEAR) || (state == SCAN)) ? idx + IDX_W'(1) : '0;
      p1Valid  <= accept;
      if (accept) p1Addr <= iPixel;
      wValid   <= p1Valid;
      wAddr    <= p1Addr;
      wData    <= incVal;
      if (state == PUBLISH) begin
        pixCount <= '0;
      end else if (accept && (pixCount != BIN_MAX)) begin
        pixCount <= pixCount + BIN_W'(1);
      end
      oRdData  <= pubBank[iRdAddr];
    end
  end

  // Running max, cumulative sum and first-crossing percentile search
  always_ff @(posedge iClk) begin
    if (!iRst_n || (state == DRAIN)) begin
      maxRun <= '0;
      cumSum <= '0;
      found  <= '0;
      for (int k = 0; k < 3; k++) thrRun[k] <= '0;
    end else if (state == SCAN) begin
      if (scanVal > maxRun) maxRun <= scanVal;
      cumSum <= cumNext;
      for (int k = 0; k < 3; k++) begin
        if (!found[k] && (cum4 >= totK[k])) begin
          thrRun[k] <= idx;
          found[k]  <= 1'b1;
        end
      end
    end
  end

  // Published results and status
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      oMaxValue      <= '0;
      oThreshPoint25 <= '0;
      oThreshPoint50 <= '0;
      oThreshPoint75 <= '0;
      oFrameDone     <= 1'b0;
      oBusy          <= 1'b1;
    end else begin
      oFrameDone <= (state == PUBLISH);
      oBusy      <= (nextState != ACCUM);
      if (state == PUBLISH) begin
        oMaxValue      <= maxRun;
        oThreshPoint25 <= (pixCount == '0) ? '0 : thrRun[0];
        oThreshPoint50 <= (pixCount == '0) ? '0 : thrRun[1];
        oThreshPoint75 <= (pixCount == '0) ? '0 : thrRun[2];
      end
    end
  end

endmodule

// File: tb/tb_histogram_builder.sv
// Directed bench for histogram_builder: frame scenarios with hand-computed
// max/percentile results and full bin readback of the published bank.
module tb_histogram_builder;

  localparam int unsigned BIN_W = 20;

  logic             iClk = 1'b0;
  logic             iRst_n;
  logic             iValid;
  logic [7:0]       iPixel;
  logic             iFrameEnd;
  logic [7:0]       iRdAddr;
  logic [BIN_W-1:0] oRdData;
  logic [BIN_W-1:0] oMaxValue;
  logic [7:0]       oThreshPoint25;
  logic [7:0]       oThreshPoint50;
  logic [7:0]       oThreshPoint75;
  logic             oBusy;
  logic             oFrameDone;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  logic [7:0] pix [$];

  histogram_builder #(.BIN_W(BIN_W), .CLR_LEN(256)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .iPixel(iPixel),
    .iFrameEnd(iFrameEnd), .iRdAddr(iRdAddr), .oRdData(oRdData),
    .oMaxValue(oMaxValue), .oThreshPoint25(oThreshPoint25),
    .oThreshPoint50(oThreshPoint50), .oThreshPoint75(oThreshPoint75),
    .oBusy(oBusy), .oFrameDone(oFrameDone)
  );

  always #5 iClk = ~iClk;

  always @(negedge iClk) if (oFrameDone === 1'b1) doneCount++;

  task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic sendPixel(input logic [7:0] v, input logic fe);
    iValid = 1'b1; iPixel = v; iFrameEnd = fe;
    tick();
    iValid = 1'b0; iFrameEnd = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (oBusy !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    checkEq(tag, n, 256);
  endtask

  // Send queued pixels (last one carries frame end) and wait for the publish
  task automatic sendFrame(input bit noise);
    int n = 0;
    for (int i = 0; i < pix.size(); i++) sendPixel(pix[i], (i == pix.size() - 1));
    if (pix.size() == 0) begin
      iFrameEnd = 1'b1;
      tick();
      iFrameEnd = 1'b0;
    end
    while (oFrameDone !== 1'b1 && n < 400) begin
      if (noise) begin
        iValid = 1'b1; iPixel = 8'd50; iFrameEnd = (n == 20);
      end
      tick();
      n++;
      iValid = 1'b0; iFrameEnd = 1'b0;
      if (noise && n == 50) checkEq("busy_during_scan", oBusy, 1);
    end
    checkEq("done_latency", n, 258);
    tick();
    checkEq("done_single_cycle", oFrameDone, 0);
  endtask

  task automatic checkResults(input string tag, input int mx, input int t25, input int t50, input int t75);
    checkEq({tag, "_max"}, oMaxValue, mx);
    checkEq({tag, "_t25"}, oThreshPoint25, t25);
    checkEq({tag, "_t50"}, oThreshPoint50, t50);
    checkEq({tag, "_t75"}, oThreshPoint75, t75);
    checkEq({tag, "_busy"}, oBusy, 0);
  endtask

  // Read every published bin and compare against counts of the queued pixels
  task automatic checkBins(input string tag);
    int exp [256];
    for (int a = 0; a < 256; a++) exp[a] = 0;
    foreach (pix[i]) exp[pix[i]]++;
    for (int a = 0; a < 256; a++) begin
      iRdAddr = 8'(a);
      tick();
      checkEq($sformatf("%s_bin%0d", tag, a), oRdData, exp[a]);
    end
  endtask

  initial begin
    int saved;
    iRst_n = 1'b0; iValid = 1'b0; iPixel = '0; iFrameEnd = 1'b0; iRdAddr = '0;
    repeat (3) tick();
    checkEq("rst_busy", oBusy, 1);
    checkEq("rst_max", oMaxValue, 0);
    checkEq("rst_t25", oThreshPoint25, 0);
    checkEq("rst_t50", oThreshPoint50, 0);
    checkEq("rst_t75", oThreshPoint75, 0);
    checkEq("rst_done", oFrameDone, 0);
    iRst_n = 1'b1;
    waitIdle("busy_fall_after_reset");
    pix.delete();
    checkBins("init");

    // Four pixels of value 10
    pix = '{8'd10, 8'd10, 8'd10, 8'd10};
    sendFrame(1'b0);
    checkResults("f10", 4, 10, 10, 10);
    checkBins("f10");

    // 100 back-to-back equal pixels exercise write forwarding
    pix.delete();
    for (int i = 0; i < 100; i++) pix.push_back(8'd200);
    sendFrame(1'b0);
    checkResults("f200", 100, 200, 200, 200);
    checkBins("f200");

    // Interleaved repeats: total 5, cum 3 at bin 5 and 5 at bin 6
    pix = '{8'd5, 8'd6, 8'd5, 8'd5, 8'd6};
    sendFrame(1'b0);
    checkResults("gap", 3, 5, 5, 6);
    checkBins("gap");

    // Empty frame publishes zeros
    pix.delete();
    sendFrame(1'b0);
    checkResults("empty", 0, 0, 0, 0);
    checkBins("empty");

    // Spread pixels; noise injected while busy must be dropped
    pix = '{8'd0, 8'd64, 8'd128, 8'd255};
    sendFrame(1'b1);
    checkResults("spread", 1, 0, 64, 128);
    checkBins("spread");

    // Next frame starts from a clean accumulate bank
    pix = '{8'd7, 8'd7, 8'd7};
    sendFrame(1'b0);
    checkResults("after_noise", 3, 7, 7, 7);
    checkBins("after_noise");

    // Reset during SCAN abandons the frame
    pix = '{8'd30, 8'd30, 8'd30, 8'd30, 8'd30};
    foreach (pix[i]) sendPixel(pix[i], (i == pix.size() - 1));
    repeat (101) tick();
    saved = doneCount;
    iRst_n = 1'b0;
    tick();
    tick();
    checkEq("midscan_rst_max", oMaxValue, 0);
    checkEq("midscan_rst_t25", oThreshPoint25, 0);
    checkEq("midscan_rst_t50", oThreshPoint50, 0);
    checkEq("midscan_rst_t75", oThreshPoint75, 0);
    checkEq("midscan_rst_busy", oBusy, 1);
    iRst_n = 1'b1;
    waitIdle("busy_fall_after_midscan_rst");
    checkEq("midscan_no_done", doneCount, saved);
    checkEq("midscan_max_after", oMaxValue, 0);
    pix.delete();
    checkBins("midscan");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
